// File: rtl/nic_host_ctrl.sv
`default_nettype none
// nic_host_ctrl: shares the NIC CPU port between round-robin TX requesters and an RX
// status poller that drains received packets into a one-deep valid/ready register.
module nic_host_ctrl #(
  parameter int PACKET_WIDTH = 64,
  parameter int NUM_REQ      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic                            rx_valid,
  output logic [PACKET_WIDTH-1:0]         rx_data,
  input  logic                            rx_ready,
  output logic [1:0]                      nic_addr,
  output logic                            nic_en,
  output logic                            nic_wr,
  output logic [PACKET_WIDTH-1:0]         nic_d_in,
  input  logic [PACKET_WIDTH-1:0]         nic_d_out
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RX_STAT   = 4'd1,
    S_RX_STAT_W = 4'd2,
    S_RX_READ   = 4'd3,
    S_RX_CAP    = 4'd4,
    S_TX_STAT   = 4'd5,
    S_TX_STAT_W = 4'd6,
    S_TX_WRITE  = 4'd7,
    S_TX_HOLD   = 4'd8
  } state_t;

  state_t                  state, state_nxt;
  logic                    turn_tx;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           rr_grant;
  logic [GW-1:0]           cand;
  logic                    rr_found;
  logic [PACKET_WIDTH-1:0] tx_data;
  logic                    ack;

  assign nic_d_in = tx_data;
  assign req_ack  = ack ? (NUM_REQ'(1) << grant) : '0;

  // First valid requester after last_grant, wrapping; falls back to last_grant if none.
  always_comb begin
    rr_grant = last_grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_grant = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    nic_en    = 1'b0;
    nic_wr    = 1'b0;
    nic_addr  = 2'b00;
    ack       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_valid && (!(|req_valid) || !turn_tx)) state_nxt = S_RX_STAT;
        else if (|req_valid)                          state_nxt = S_TX_STAT;
      end
      S_RX_STAT: begin
        nic_en    = 1'b1;
        nic_addr  = 2'b01;
        state_nxt = S_RX_STAT_W;
      end
      S_RX_STAT_W: state_nxt = nic_d_out[0] ? S_RX_READ : S_IDLE;
      S_RX_READ: begin
        nic_en    = 1'b1;
        nic_addr  = 2'b00;
        state_nxt = S_RX_CAP;
      end
      S_RX_CAP: state_nxt = S_IDLE;
      S_TX_STAT: begin
        nic_en    = 1'b1;
        nic_addr  = 2'b11;
        state_nxt = S_TX_STAT_W;
      end
      S_TX_STAT_W: begin
        state_nxt = S_IDLE;
        // A zero packet looks empty to the NIC, so it is acked without being written.
        if (req_valid[grant]) begin
          if (tx_data == '0)      ack       = 1'b1;
          else if (!nic_d_out[0]) state_nxt = S_TX_WRITE;
        end
      end
      S_TX_WRITE: begin
        nic_en    = 1'b1;
        nic_wr    = 1'b1;
        nic_addr  = 2'b10;
        ack       = 1'b1;
        state_nxt = S_TX_HOLD;
      end
      S_TX_HOLD: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_tx    <= 1'b0;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      tx_data    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        S_RX_STAT: turn_tx <= 1'b1;
        S_RX_CAP: begin
          rx_data  <= nic_d_out;
          rx_valid <= 1'b1;
        end
        S_TX_STAT: begin
          grant   <= rr_grant;
          tx_data <= req_data[int'(rr_grant)*PACKET_WIDTH +: PACKET_WIDTH];
          turn_tx <= 1'b0;
        end
        default: ;
      endcase
      if (ack) last_grant <= grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nic_host_ctrl.sv
`default_nettype none
// Bench for nic_host_ctrl: NIC register model, ack scoreboard, vector table and
// hand-written sequences for busy, RX backpressure, withdrawal, reset and alternation.
module tb_nic_host_ctrl;
  localparam int PW = 64;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*PW-1:0] req_data;
  logic [NR-1:0]    req_ack;
  logic             rx_valid;
  logic [PW-1:0]    rx_data;
  logic             rx_ready;
  logic [1:0]       nic_addr;
  logic             nic_en;
  logic             nic_wr;
  logic [PW-1:0]    nic_d_in;
  logic [PW-1:0]    nic_d_out;

  nic_host_ctrl #(.PACKET_WIDTH(PW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_en(nic_en), .nic_wr(nic_wr), .nic_d_in(nic_d_in),
    .nic_d_out(nic_d_out)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic [PW-1:0] data;} exp_t;
  typedef struct {int idx; logic onehot; logic [3:0] pins; logic [PW-1:0] din;} obs_t;
  typedef struct {logic [NR-1:0] mask; int idx; logic zero;} vec_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  logic [1:0] acc_q[$];
  obs_t       mon_o;
  int         obs_rd;
  int         bad_writes;
  int         n_cmp;
  int         n_err;

  logic          in_status;
  logic [PW-1:0] in_buf;
  int            busy_until;
  int            out_polls;
  int            rx_polls;

  // NIC register model: read data appears the cycle after the read strobe.
  initial begin
    nic_d_out = '0;
    out_polls = 0;
    rx_polls  = 0;
    forever begin
      @(posedge clk);
      if (nic_en && !nic_wr) begin
        case (nic_addr)
          2'b00: nic_d_out <= in_buf;
          2'b01: begin
            nic_d_out <= {{(PW-1){1'b0}}, in_status};
            rx_polls++;
          end
          2'b11: begin
            nic_d_out <= {{(PW-1){1'b0}}, (out_polls < busy_until)};
            out_polls++;
          end
          default: nic_d_out <= '0;
        endcase
      end
    end
  end

  initial begin
    bad_writes = 0;
    forever begin
      @(negedge clk);
      if (nic_en) acc_q.push_back(nic_addr);
      if (|req_ack) begin
        mon_o.idx = -1;
        for (int i = 0; i < NR; i++) if (req_ack[i]) mon_o.idx = i;
        mon_o.onehot = $onehot(req_ack);
        mon_o.pins   = {nic_en, nic_wr, nic_addr};
        mon_o.din    = nic_d_in;
        obs_q.push_back(mon_o);
      end else if (nic_en && nic_wr) begin
        bad_writes++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int k = 0;
    while ((obs_q.size() - obs_rd) < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic check_acks(input string tag);
    exp_t e;
    obs_t o;
    chk({tag, "_ack_count"}, obs_q.size() - obs_rd, exp_q.size());
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      chk({tag, "_ack_idx"}, o.idx, e.idx);
      chk({tag, "_ack_onehot"}, o.onehot, 1);
      chk({tag, "_ack_pins"}, o.pins, (e.data == '0) ? 4'b0000 : 4'b1110);
      chk({tag, "_ack_d_in"}, o.din, e.data);
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  function automatic logic [PW-1:0] pkt(input int e, input int i);
    return {32'hC0DE_0000, 8'(e), 16'h0000, 8'(i)};
  endfunction

  initial begin
    vec_t tbl[8];
    int   k;
    int   p0;
    int   a0;
    logic seen;
    logic [1:0] exp_acc[8];

    tbl[0] = '{4'b0001, 0, 1'b0};
    tbl[1] = '{4'b0110, 1, 1'b0};
    tbl[2] = '{4'b0110, 2, 1'b0};
    tbl[3] = '{4'b1001, 3, 1'b0};
    tbl[4] = '{4'b1001, 0, 1'b0};
    tbl[5] = '{4'b1100, 2, 1'b0};
    tbl[6] = '{4'b0011, 0, 1'b0};
    tbl[7] = '{4'b0010, 1, 1'b1};
    exp_acc = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};

    n_cmp = 0; n_err = 0; obs_rd = 0;
    reset = 1'b0; req_valid = '0; req_data = '0; rx_ready = 1'b0;
    in_status = 1'b0; in_buf = '0; busy_until = 0;

    // Reset values
    repeat (2) step();
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_d_in", nic_d_in, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_pins", {nic_en, nic_wr, nic_addr}, 0);
    reset = 1'b1;
    step();
    obs_rd = obs_q.size();

    // Round-robin with all requesters held
    for (int i = 0; i < NR; i++) req_data[i*PW +: PW] = 64'hA0 + i;
    for (int j = 0; j < 5; j++) exp_q.push_back('{j % NR, 64'hA0 + (j % NR)});
    req_valid = 4'b1111;
    wait_acks(5, 300);
    req_valid = '0;
    repeat (4) step();
    check_acks("rr");

    // Vector table
    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < NR; i++) req_data[i*PW +: PW] = tbl[e].zero ? '0 : pkt(e, i);
      exp_q.push_back('{tbl[e].idx, tbl[e].zero ? '0 : pkt(e, tbl[e].idx)});
      req_valid = tbl[e].mask;
      wait_acks(1, 80);
      req_valid = '0;
      repeat (4) step();
      check_acks("vec");
    end

    // Output buffer busy for three polls
    req_data[2*PW +: PW] = 64'hB0B0;
    p0 = out_polls;
    busy_until = out_polls + 3;
    exp_q.push_back('{2, 64'hB0B0});
    req_valid = 4'b0100;
    wait_acks(1, 150);
    chk("busy_polls", out_polls - p0, 4);
    req_valid = '0;
    repeat (4) step();
    check_acks("busy");
    chk("busy_no_stray_write", bad_writes, 0);

    // RX drain with backpressure
    in_buf = 64'hDEAD_BEEF; in_status = 1'b1; rx_ready = 1'b0;
    k = 0;
    while (!rx_valid && k < 40) begin step(); k++; end
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data", rx_data, 64'hDEAD_BEEF);
    p0 = rx_polls;
    repeat (20) step();
    chk("rx_hold_no_poll", rx_polls - p0, 0);
    chk("rx_valid_held", rx_valid, 1);
    in_status = 1'b0; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_valid_clear", rx_valid, 0);

    // Requester 3 withdraws during the status wait
    req_data[3*PW +: PW] = 64'hF00D;
    req_valid = 4'b1000;
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      step(); k++;
      if (nic_en && nic_addr == 2'b11) seen = 1'b1;
    end
    chk("wd_stat_seen", seen, 1);
    step();
    req_valid = '0;
    repeat (8) step();
    check_acks("withdraw");
    chk("wd_no_write", bad_writes, 0);

    // Reset while in TX_WRITE
    req_data[0 +: PW] = 64'h1234;
    req_valid = 4'b0001;
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      step(); k++;
      if (nic_en && nic_addr == 2'b11) seen = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rstw_in_write", {nic_en, nic_wr, nic_addr}, 4'b1110);
    reset = 1'b0; req_valid = '0;
    #1;
    chk("rstw_pins", {nic_en, nic_wr, nic_addr}, 0);
    chk("rstw_ack", req_ack, 0);
    chk("rstw_d_in", nic_d_in, 0);
    step();
    chk("rstw_pins_next", {nic_en, nic_wr, nic_addr, req_ack}, 0);
    check_acks("rst_mid");

    // RX/TX alternation from reset, both sides always eligible
    in_status = 1'b1; in_buf = 64'h55; rx_ready = 1'b1;
    req_data[0 +: PW] = 64'h77;
    req_valid = 4'b0001;
    exp_q.push_back('{0, 64'h77});
    exp_q.push_back('{0, 64'h77});
    a0 = acc_q.size();
    reset = 1'b1;
    k = 0;
    while ((acc_q.size() - a0) < 8 && k < 80) begin step(); k++; end
    req_valid = '0; in_status = 1'b0;
    repeat (6) step();
    chk("alt_acc_count_min", (acc_q.size() - a0) >= 8, 1);
    for (int j = 0; j < 8; j++)
      if (a0 + j < acc_q.size()) chk("alt_addr", acc_q[a0 + j], exp_acc[j]);
    check_acks("alt");
    chk("alt_rx_data", rx_data, 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
